// File: rtl/xgmii_tx_framer.sv
// XGMII transmit framer: turns a 64-bit packet stream into packed 72-bit XGMII words.
// Adds START/preamble/SFD, places TERM, enforces the inter-packet gap, and
// aborts frames with ERR on underrun.
//
// Ports:
//   clk, reset_n    : XGMII TX clock, synchronous active-low reset
//   s_data[63:0]    : packet bytes, byte k in [8k+7:8k], byte 0 goes out on lane 0
//   s_valid/s_ready : beat handshake (s_ready is high only in DATA and DROP)
//   s_endofpacket   : last beat of a frame
//   s_empty[2:0]    : unused high-order bytes on the last beat
//   xgmii_tx[71:0]  : registered packed word, lane i = {ctrl, byte} at [9i+8:9i]
//   frame_count     : frames terminated normally (wraps)
//   abort_count     : frames aborted by underrun (saturates)
module xgmii_tx_framer #(
    parameter int unsigned IPG_WORDS = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_endofpacket,
    input  logic [2:0]  s_empty,
    output logic [71:0] xgmii_tx,
    output logic [15:0] frame_count,
    output logic [15:0] abort_count
);

    localparam logic [8:0] L_IDLE  = 9'h107;
    localparam logic [8:0] L_START = 9'h1FB;
    localparam logic [8:0] L_TERM  = 9'h1FD;
    localparam logic [8:0] L_ERR   = 9'h1FE;

    localparam logic [71:0] IDLE_W  = {8{L_IDLE}};
    localparam logic [71:0] START_W = {9'h0D5, {6{9'h055}}, L_START};
    localparam logic [71:0] TERM_W  = {{7{L_IDLE}}, L_TERM};
    localparam logic [71:0] ABORT_W = {{6{L_IDLE}}, L_TERM, L_ERR};

    localparam logic [3:0] IPG_LOAD = 4'(IPG_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_TERM,
        ST_DROP,
        ST_IPG
    } state_t;

    state_t      state_q;
    logic [3:0]  ipg_q;
    logic [71:0] tx_q;
    logic [15:0] frame_q;
    logic [15:0] abort_q;

    logic [3:0]  n_bytes;
    logic [71:0] data_w;
    logic [71:0] last_w;

    // Full data word and short last word (data, TERM, then IDLE fill).
    always_comb begin
        n_bytes = 4'd8 - {1'b0, s_empty};
        data_w  = '0;
        last_w  = '0;
        for (int i = 0; i < 8; i++) begin
            data_w[9*i +: 9] = {1'b0, s_data[8*i +: 8]};
            if (4'(i) < n_bytes) begin
                last_w[9*i +: 9] = {1'b0, s_data[8*i +: 8]};
            end else if (4'(i) == n_bytes) begin
                last_w[9*i +: 9] = L_TERM;
            end else begin
                last_w[9*i +: 9] = L_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            tx_q    <= IDLE_W;
            ipg_q   <= '0;
            frame_q <= '0;
            abort_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    tx_q <= IDLE_W;
                    if (s_valid) begin
                        tx_q    <= START_W;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!s_valid) begin
                        tx_q    <= ABORT_W;
                        state_q <= ST_DROP;
                        if (abort_q != 16'hFFFF) begin
                            abort_q <= abort_q + 16'd1;
                        end
                    end else if (!s_endofpacket) begin
                        tx_q <= data_w;
                    end else if (s_empty == 3'd0) begin
                        // Full last beat: TERM needs a word of its own.
                        tx_q    <= data_w;
                        state_q <= ST_TERM;
                    end else begin
                        tx_q    <= last_w;
                        state_q <= ST_IPG;
                        ipg_q   <= IPG_LOAD;
                        frame_q <= frame_q + 16'd1;
                    end
                end
                ST_TERM: begin
                    tx_q    <= TERM_W;
                    state_q <= ST_IPG;
                    ipg_q   <= IPG_LOAD;
                    frame_q <= frame_q + 16'd1;
                end
                ST_DROP: begin
                    tx_q <= IDLE_W;
                    if (s_valid && s_endofpacket) begin
                        state_q <= ST_IPG;
                        ipg_q   <= IPG_LOAD;
                    end
                end
                ST_IPG: begin
                    // Leaving on the count of 1 lets IDLE turn a waiting
                    // s_valid into START right after the last gap word.
                    tx_q <= IDLE_W;
                    if (ipg_q <= 4'd1) begin
                        state_q <= ST_IDLE;
                        ipg_q   <= '0;
                    end else begin
                        ipg_q <= ipg_q - 4'd1;
                    end
                end
                default: begin
                    tx_q    <= IDLE_W;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready     = (state_q == ST_DATA) || (state_q == ST_DROP);
    assign xgmii_tx    = tx_q;
    assign frame_count = frame_q;
    assign abort_count = abort_q;

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Bench for xgmii_tx_framer: a frame-level model queues the expected words,
// checked every cycle, plus literal lane checks on the recorded stream.
module tb_xgmii_tx_framer;

    localparam logic [71:0] IDLE_W  = {8{9'h107}};
    localparam logic [71:0] START_W = {9'h0D5, {6{9'h055}}, 9'h1FB};
    localparam logic [71:0] TERM_W  = {{7{9'h107}}, 9'h1FD};
    localparam logic [71:0] ERR_W   = {{6{9'h107}}, 9'h1FD, 9'h1FE};

    logic        clk;
    logic        reset_n;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_endofpacket;
    logic [2:0]  s_empty;
    logic        sel;
    logic        v2, v3;
    logic        rdy2, rdy3;
    logic [71:0] tx2, tx3;
    logic [15:0] fc2, fc3, ac2, ac3;

    assign v2 = s_valid && !sel;
    assign v3 = s_valid && sel;

    xgmii_tx_framer #(.IPG_WORDS(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(v2),
        .s_ready(rdy2), .s_endofpacket(s_endofpacket), .s_empty(s_empty),
        .xgmii_tx(tx2), .frame_count(fc2), .abort_count(ac2)
    );

    xgmii_tx_framer #(.IPG_WORDS(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(v3),
        .s_ready(rdy3), .s_endofpacket(s_endofpacket), .s_empty(s_empty),
        .xgmii_tx(tx3), .frame_count(fc3), .abort_count(ac3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int exp_frame = 0;
    int exp_abort = 0;

    logic [71:0] q[$];
    logic [71:0] hist[$];
    logic [15:0] histfc[$];
    logic [71:0] exp_w;

    wire        rdy = sel ? rdy3 : rdy2;
    wire [71:0] tx  = sel ? tx3 : tx2;
    wire [71:0] txo = sel ? tx2 : tx3;
    wire [15:0] fc  = sel ? fc3 : fc2;
    wire [15:0] ac  = sel ? ac3 : ac2;

    task automatic chk(input string nm, input logic [71:0] got,
                       input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [71:0] dword(input logic [63:0] d);
        logic [71:0] w;
        for (int k = 0; k < 8; k++) w[9*k +: 9] = {1'b0, d[8*k +: 8]};
        return w;
    endfunction

    function automatic logic [71:0] lword(input logic [63:0] d, input int n);
        logic [71:0] w;
        for (int k = 0; k < 8; k++) begin
            if (k < n)       w[9*k +: 9] = {1'b0, d[8*k +: 8]};
            else if (k == n) w[9*k +: 9] = 9'h1FD;
            else             w[9*k +: 9] = 9'h107;
        end
        return w;
    endfunction

    function automatic int find_start(input int from);
        for (int i = from; i < hist.size(); i++)
            if (hist[i][8:0] == 9'h1FB) return i;
        return -1;
    endfunction

    // Every cycle: selected DUT must match the model queue (IDLE when
    // empty), the parked DUT must stay idle.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            exp_w = (q.size() > 0) ? q.pop_front() : IDLE_W;
            chk("word", tx, exp_w);
            chk("parked_idle", txo, IDLE_W);
            hist.push_back(tx);
            histfc.push_back(fc);
        end
    end

    // Called at a negedge with the beat driven; returns at the negedge
    // after the edge that accepted it.
    task automatic wait_acc();
        bit ok = 1'b0;
        int t  = 0;
        while (!ok && t < 50) begin
            if (rdy) ok = 1'b1;
            @(negedge clk);
            t++;
        end
        if (!ok) chk("accept_timeout", 72'd0, 72'd1);
    endtask

    task automatic send_frame(input int nbytes, input int base,
                              input int gap_at);
        int nb = (nbytes + 7) / 8;
        int ipg = sel ? 3 : 2;
        bit drop = 1'b0;
        logic [63:0] d;
        logic [2:0] e;
        bit last;
        q.push_back(START_W);
        for (int b = 0; b < nb; b++) begin
            last = (b == nb - 1);
            e = last ? 3'(nb * 8 - nbytes) : 3'd0;
            if (b == gap_at) begin
                s_valid = 1'b0;
                q.push_back(ERR_W);
                drop = 1'b1;
                @(negedge clk);
            end
            for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(base + b * 8 + k);
            s_data = d;
            s_endofpacket = last;
            s_empty = e;
            s_valid = 1'b1;
            if (drop) q.push_back(IDLE_W);
            else if (!last) q.push_back(dword(d));
            else if (e != 3'd0) q.push_back(lword(d, 8 - int'(e)));
            else begin
                q.push_back(dword(d));
                q.push_back(TERM_W);
            end
            wait_acc();
        end
        s_valid = 1'b0;
        s_endofpacket = 1'b0;
        for (int i = 0; i < ipg; i++) q.push_back(IDLE_W);
        if (drop) exp_abort++;
        else exp_frame++;
    endtask

    int mark;
    int s;

    initial begin
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_endofpacket = 1'b0;
        s_empty = '0;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        reset_n = 1'b1;

        // Idle after reset release
        repeat (10) @(negedge clk);
        chk("rst_ready", 72'(rdy), 72'd0);
        chk("rst_fc", 72'(fc), 72'd0);
        chk("rst_ac", 72'(ac), 72'd0);

        // 16-byte frames back to back, IPG 2
        mark = hist.size();
        send_frame(16, 8'h00, -1);
        send_frame(16, 8'h10, -1);
        repeat (8) @(negedge clk);
        s = find_start(mark);
        if (s < 0) chk("b2b_start_found", 72'd0, 72'd1);
        else begin
            chk("b2b_s_l0", 72'(hist[s][8:0]), 72'h1FB);
            chk("b2b_s_l7", 72'(hist[s][71:63]), 72'h0D5);
            chk("b2b_d1_l0", 72'(hist[s+1][8:0]), 72'h000);
            chk("b2b_d1_l7", 72'(hist[s+1][71:63]), 72'h007);
            chk("b2b_d2_l0", 72'(hist[s+2][8:0]), 72'h008);
            chk("b2b_d2_l7", 72'(hist[s+2][71:63]), 72'h00F);
            chk("b2b_term", 72'(hist[s+3][8:0]), 72'h1FD);
            chk("b2b_ipg1", hist[s+4], IDLE_W);
            chk("b2b_ipg2", hist[s+5], IDLE_W);
            chk("b2b_s2", 72'(hist[s+6][8:0]), 72'h1FB);
            chk("b2b_fc1", 72'(histfc[s+6]), 72'd1);
        end
        chk("b2b_fc", 72'(fc), 72'(exp_frame));

        // 11-byte frame, TERM on lane 3
        mark = hist.size();
        send_frame(11, 8'h00, -1);
        repeat (6) @(negedge clk);
        s = find_start(mark);
        if (s < 0) chk("f11_start_found", 72'd0, 72'd1);
        else begin
            chk("f11_l0", 72'(hist[s+2][8:0]), 72'h008);
            chk("f11_l1", 72'(hist[s+2][17:9]), 72'h009);
            chk("f11_l2", 72'(hist[s+2][26:18]), 72'h00A);
            chk("f11_l3", 72'(hist[s+2][35:27]), 72'h1FD);
            chk("f11_b35", 72'(hist[s+2][35]), 72'd1);
            chk("f11_l47", 72'(hist[s+2][71:36]), 72'({4{9'h107}}));
            chk("f11_ipg1", hist[s+3], IDLE_W);
            chk("f11_ipg2", hist[s+4], IDLE_W);
        end

        // 9-byte frame, s_empty = 7
        mark = hist.size();
        send_frame(9, 8'h20, -1);
        repeat (6) @(negedge clk);
        s = find_start(mark);
        if (s < 0) chk("f9_start_found", 72'd0, 72'd1);
        else begin
            chk("f9_l0", 72'(hist[s+2][8:0]), 72'h028);
            chk("f9_l1", 72'(hist[s+2][17:9]), 72'h1FD);
            chk("f9_l27", 72'(hist[s+2][71:18]), 72'({6{9'h107}}));
        end
        chk("f9_fc", 72'(fc), 72'd4);

        // Underrun after beat 1 of a 4-beat frame
        mark = hist.size();
        send_frame(32, 8'h40, 1);
        repeat (6) @(negedge clk);
        s = find_start(mark);
        if (s < 0) chk("ur_start_found", 72'd0, 72'd1);
        else begin
            chk("ur_d0", 72'(hist[s+1][8:0]), 72'h040);
            chk("ur_err_l0", 72'(hist[s+2][8:0]), 72'h1FE);
            chk("ur_err_l1", 72'(hist[s+2][17:9]), 72'h1FD);
            chk("ur_err_rest", 72'(hist[s+2][71:18]), 72'({6{9'h107}}));
            for (int i = 3; i < 8; i++) chk("ur_drop_idle", hist[s+i], IDLE_W);
        end
        chk("ur_ac", 72'(ac), 72'd1);
        chk("ur_fc", 72'(fc), 72'd4);
        chk("ur_ac_model", 72'(ac), 72'(exp_abort));

        // Reset during DATA
        q.push_back(START_W);
        for (int b = 0; b < 2; b++) begin
            s_data = {8{8'(8'h80 + b)}};
            s_endofpacket = 1'b0;
            s_empty = 3'd0;
            s_valid = 1'b1;
            q.push_back(dword(s_data));
            wait_acc();
        end
        reset_n = 1'b0;
        s_valid = 1'b0;
        q.delete();
        mark = hist.size();
        @(negedge clk);
        chk("mrst_word", hist[mark], IDLE_W);
        chk("mrst_ready", 72'(rdy), 72'd0);
        chk("mrst_fc", 72'(fc), 72'd0);
        chk("mrst_ac", 72'(ac), 72'd0);
        reset_n = 1'b1;
        exp_frame = 0;
        exp_abort = 0;
        @(negedge clk);
        send_frame(16, 8'hA0, -1);
        repeat (6) @(negedge clk);
        chk("mrst_fc_after", 72'(fc), 72'd1);

        // IPG 3, back-to-back 8-byte frames
        repeat (4) @(negedge clk);
        sel = 1'b1;
        exp_frame = 0;
        mark = hist.size();
        for (int f = 0; f < 4; f++) send_frame(8, 8'hC0 + f * 8, -1);
        repeat (8) @(negedge clk);
        s = find_start(mark);
        if (s < 0) chk("ipg3_start_found", 72'd0, 72'd1);
        else begin
            chk("ipg3_d", 72'(hist[s+1][8:0]), 72'h0C0);
            chk("ipg3_term", 72'(hist[s+2][8:0]), 72'h1FD);
            chk("ipg3_i1", hist[s+3], IDLE_W);
            chk("ipg3_i2", hist[s+4], IDLE_W);
            chk("ipg3_i3", hist[s+5], IDLE_W);
            chk("ipg3_s2", 72'(hist[s+6][8:0]), 72'h1FB);
            chk("ipg3_fc_s2", 72'(histfc[s+6]), 72'd1);
        end
        chk("ipg3_fc", 72'(fc), 72'd4);
        chk("ipg3_fc_model", 72'(fc), 72'(exp_frame));

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
